// File: rtl/mem_burst_responder.sv
// Word-addressed memory behind a single-outstanding request/response handshake:
// fixed-latency single reads, critical-word-first burst reads and acknowledged writes.
module mem_burst_responder #(
    parameter int unsigned LATENCY         = 4,
    parameter int unsigned BURST_LEN       = 8,
    parameter int unsigned ADDR_WORDS_LOG2 = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic        req_burst,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_last,
    output logic        busy
);
    localparam int unsigned AW    = ADDR_WORDS_LOG2;
    localparam int unsigned LB    = $clog2(BURST_LEN);
    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic [1:0] {StIdle, StWait, StBeat} state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [LB-1:0] beat_q, beat_d;
    logic          wr_q, wr_d;
    logic          burst_q, burst_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [15:0]   wdata_q, wdata_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_last_q, rsp_last_d;
    logic [15:0]   rsp_data_q, rsp_data_d;
    logic          mem_we;
    logic [AW-1:0] rd_idx;
    logic [15:0]   mem [DEPTH];
    logic          unused_addr_lsb;

    assign unused_addr_lsb = req_addr[0];

    // Burst beats wrap inside the aligned block; upper index bits stay fixed.
    assign rd_idx = {idx_q[AW-1:LB], idx_q[LB-1:0] + beat_q};

    assign req_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign rsp_valid = rsp_valid_q;
    assign rsp_last  = rsp_last_q;
    assign rsp_data  = rsp_data_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        beat_d      = beat_q;
        wr_d        = wr_q;
        burst_d     = burst_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_last_d  = 1'b0;
        rsp_data_d  = 16'h0000;
        mem_we      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d = StWait;
                    cnt_d   = 4'(LATENCY - 1);
                    beat_d  = '0;
                    wr_d    = req_wr;
                    burst_d = req_burst;
                    idx_d   = req_addr[AW:1];
                    wdata_d = req_wdata;
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    rsp_valid_d = 1'b1;
                    if (wr_q) begin
                        mem_we     = 1'b1;
                        rsp_last_d = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        rsp_data_d = mem[rd_idx];
                        if (burst_q) begin
                            beat_d  = beat_q + 1'b1;
                            state_d = StBeat;
                        end else begin
                            rsp_last_d = 1'b1;
                            state_d    = StIdle;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StBeat: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = mem[rd_idx];
                beat_d      = beat_q + 1'b1;
                if (beat_q == LB'(BURST_LEN - 1)) begin
                    rsp_last_d = 1'b1;
                    beat_d     = '0;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            beat_q      <= '0;
            wr_q        <= 1'b0;
            burst_q     <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= 16'h0000;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_data_q  <= 16'h0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            beat_q      <= beat_d;
            wr_q        <= wr_d;
            burst_q     <= burst_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Storage has no reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule
